// File: rtl/rsa_mul.sv
// Sequential shift-and-add unsigned multiplier producing the full 2*WIDTH-bit product.
// Each multiplier bit takes one ADD/SHIFT state pair, with a start/done handshake.
module rsa_mul #(
  parameter int WIDTH = 128,
  parameter int CW    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               busy,
  output logic [1:0]         state_out,
  output logic [CW-1:0]      count_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ADD   = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_carry;
  logic [CW-1:0]    r_count;

  logic [WIDTH:0]   w_sum;
  logic [CW-1:0]    w_cnt_nxt;

  // One extra bit on the adder keeps the carry, so the product never overflows.
  assign w_sum     = {1'b0, r_hi} + {1'b0, r_m};
  assign w_cnt_nxt = r_count + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_m     <= multiplicand;
            r_hi    <= '0;
            r_lo    <= multiplier;
            r_carry <= 1'b0;
            r_count <= '0;
            r_state <= ADD;
          end
        end
        ADD: begin
          if (r_lo[0]) {r_carry, r_hi} <= w_sum;
          else         r_carry         <= 1'b0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          // Carry drops into the top of acc_hi as the whole accumulator shifts right.
          {r_hi, r_lo} <= {r_carry, r_hi, r_lo[WIDTH-1:1]};
          r_carry      <= 1'b0;
          r_count      <= w_cnt_nxt;
          r_state      <= (w_cnt_nxt == CW'(WIDTH)) ? DONE : ADD;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign product   = {r_hi, r_lo};
  assign done      = (r_state == DONE);
  assign busy      = (r_state == ADD) || (r_state == SHIFT);
  assign state_out = r_state;
  assign count_out = r_count;

endmodule

// File: tb/tb_rsa_mul.sv
// Bench for rsa_mul: a 128-bit instance and an 8-bit instance checked against
// a plain-arithmetic product model with cycle-exact latency expectations.
module tb_rsa_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  // 128-bit instance
  logic         s_start;
  logic [127:0] s_a, s_b;
  logic [255:0] d_prod;
  logic         d_done, d_busy;
  logic [1:0]   d_state;
  logic [7:0]   d_cnt;
  // 8-bit instance
  logic         t_start;
  logic [7:0]   t_a, t_b;
  logic [15:0]  e_prod;
  logic         e_done, e_busy;
  logic [1:0]   e_state;
  logic [3:0]   e_cnt;

  int n_cmp = 0;
  int n_err = 0;

  rsa_mul #(.WIDTH(128), .CW(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(s_start),
    .multiplicand(s_a), .multiplier(s_b),
    .product(d_prod), .done(d_done), .busy(d_busy),
    .state_out(d_state), .count_out(d_cnt)
  );

  rsa_mul #(.WIDTH(8), .CW(4)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(t_start),
    .multiplicand(t_a), .multiplier(t_b),
    .product(e_prod), .done(e_done), .busy(e_busy),
    .state_out(e_state), .count_out(e_cnt)
  );

  function automatic logic [255:0] ref_mul(input logic [127:0] a, input logic [127:0] b);
    return {128'd0, a} * {128'd0, b};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present operands and start so the next rising edge is the accepting edge (edge 0).
  task automatic launch(input logic [127:0] a, input logic [127:0] b);
    s_a = a; s_b = b; s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (d_state !== 2'b00 || d_prod !== 256'd0 || d_done !== 1'b0 || d_busy !== 1'b0 || d_cnt !== 8'd0) begin
        n_err++;
        $display("FAIL reset_hold: state=%b prod=%h done=%b busy=%b cnt=%0d want 00/0/0/0/0", d_state, d_prod, d_done, d_busy, d_cnt);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (d_state !== 2'b00 || d_prod !== 256'd0 || d_done !== 1'b0 || d_busy !== 1'b0 || d_cnt !== 8'd0 ||
          e_state !== 2'b00 || e_prod !== 16'd0 || e_done !== 1'b0 || e_busy !== 1'b0 || e_cnt !== 4'd0) begin
        n_err++;
        $display("FAIL idle_after_reset: state=%b prod=%h done=%b busy=%b cnt=%0d (8b state=%b) want idle zeros", d_state, d_prod, d_done, d_busy, d_cnt, e_state);
      end
    end
  endtask

  task automatic test_basic;
    logic [255:0] exp_p;
    exp_p = 256'd121932631112635269;
    launch(128'd123456789, 128'd987654321);
    n_cmp++;
    if (d_state !== 2'b01 || d_busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_accept: state=%b busy=%b want 01/1", d_state, d_busy);
    end
    for (int e = 1; e < 256; e++) begin
      tick();
      n_cmp++;
      if (d_busy !== 1'b1 || d_done !== 1'b0 || d_cnt !== 8'(e / 2) ||
          d_state !== ((e % 2) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL basic_busy edge %0d: busy=%b done=%b cnt=%0d state=%b want 1/0/%0d/%b", e, d_busy, d_done, d_cnt, d_state, e / 2, (e % 2) ? 2'b10 : 2'b01);
      end
    end
    tick();
    n_cmp++;
    if (d_done !== 1'b1 || d_busy !== 1'b0 || d_state !== 2'b11 || d_prod !== exp_p ||
        d_prod !== ref_mul(128'd123456789, 128'd987654321) || d_cnt !== 8'd128) begin
      n_err++;
      $display("FAIL basic_done: done=%b busy=%b state=%b prod=%0d cnt=%0d want 1/0/11/%0d/128", d_done, d_busy, d_state, d_prod, d_cnt, exp_p);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (d_done !== 1'b1 || d_prod !== exp_p || d_cnt !== 8'd128) begin
        n_err++;
        $display("FAIL basic_hold: done=%b prod=%0d cnt=%0d want 1/%0d/128", d_done, d_prod, d_cnt, exp_p);
      end
    end
  endtask

  task automatic test_max;
    logic [255:0] exp_p;
    exp_p = {{127{1'b1}}, 1'b0, {127{1'b0}}, 1'b1};
    launch({128{1'b1}}, {128{1'b1}});
    repeat (256) tick();
    n_cmp++;
    if (d_done !== 1'b1 || d_prod !== exp_p || d_prod !== ref_mul({128{1'b1}}, {128{1'b1}})) begin
      n_err++;
      $display("FAIL max_operands: done=%b prod=%h want 1/%h", d_done, d_prod, exp_p);
    end
  endtask

  task automatic test_zero_busy_ignore;
    launch(128'd0, {128{1'b1}});
    repeat (49) tick();
    s_a = 128'd5; s_b = 128'd7; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    n_cmp++;
    if (d_busy !== 1'b1 || d_cnt !== 8'd25 || d_state !== 2'b01) begin
      n_err++;
      $display("FAIL busy_ignore edge50: busy=%b cnt=%0d state=%b want 1/25/01", d_busy, d_cnt, d_state);
    end
    repeat (205) tick();
    n_cmp++;
    if (d_done !== 1'b0) begin
      n_err++;
      $display("FAIL zero_no_early_done: done=%b at edge 255 want 0", d_done);
    end
    tick();
    n_cmp++;
    if (d_done !== 1'b1 || d_prod !== 256'd0 || d_cnt !== 8'd128) begin
      n_err++;
      $display("FAIL zero_operand: done=%b prod=%0d cnt=%0d want 1/0/128", d_done, d_prod, d_cnt);
    end
  endtask

  task automatic test_random;
    logic [127:0] a, b;
    int cyc;
    for (int r = 0; r < 5; r++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      if (r == 3) b = b >> $urandom_range(100, 127);
      if (r == 4) a[127] = 1'b1;
      launch(a, b);
      cyc = 0;
      while (d_done !== 1'b1 && cyc < 600) begin
        tick();
        cyc++;
      end
      n_cmp++;
      if (cyc != 256 || d_prod !== ref_mul(a, b) || d_cnt !== 8'd128) begin
        n_err++;
        $display("FAIL random_%0d: cycles=%0d prod=%h cnt=%0d want 256/%h/128", r, cyc, d_prod, d_cnt, ref_mul(a, b));
      end
    end
  endtask

  task automatic test_back_to_back;
    t_a = 8'd255; t_b = 8'd255; t_start = 1'b1;
    tick();                                   // edge 0
    repeat (15) tick();                       // edges 1..15
    n_cmp++;
    if (e_done !== 1'b0 || e_busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_pre_done: done=%b busy=%b at edge 15 want 0/1", e_done, e_busy);
    end
    tick();                                   // edge 16
    n_cmp++;
    if (e_done !== 1'b1 || e_prod !== 16'hFE01 || e_cnt !== 4'd8) begin
      n_err++;
      $display("FAIL b2b_first: done=%b prod=%h cnt=%0d want 1/fe01/8", e_done, e_prod, e_cnt);
    end
    t_a = 8'd3; t_b = 8'd5;
    tick();                                   // edge 17: relaunch
    n_cmp++;
    if (e_done !== 1'b0 || e_state !== 2'b01 || e_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL b2b_relaunch: done=%b state=%b cnt=%0d want 0/01/0", e_done, e_state, e_cnt);
    end
    repeat (15) tick();                       // edges 18..32
    n_cmp++;
    if (e_done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second_early: done=%b at edge 32 want 0", e_done);
    end
    tick();                                   // edge 33
    n_cmp++;
    if (e_done !== 1'b1 || e_prod !== 16'd15) begin
      n_err++;
      $display("FAIL b2b_second: done=%b prod=%0d want 1/15", e_done, e_prod);
    end
    t_start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    logic [127:0] p;
    p = 128'd1 << 127;
    launch(p, p);
    repeat (100) tick();                      // edge 100
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (d_state !== 2'b00 || d_prod !== 256'd0 || d_cnt !== 8'd0 || d_busy !== 1'b0 || d_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_abort: state=%b prod=%h cnt=%0d busy=%b done=%b want 00/0/0/0/0", d_state, d_prod, d_cnt, d_busy, d_done);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    launch(128'd2, 128'd3);
    repeat (256) tick();
    n_cmp++;
    if (d_done !== 1'b1 || d_prod !== 256'd6) begin
      n_err++;
      $display("FAIL reset_mid_relaunch: done=%b prod=%0d want 1/6", d_done, d_prod);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    s_start = 1'b0; s_a = '0; s_b = '0;
    t_start = 1'b0; t_a = '0; t_b = '0;
    test_reset();
    test_basic();
    test_max();
    test_zero_busy_ignore();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
